// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority; external loader is forced after MAXWAIT denials.
// Optional macro RF_WR_ARB_FORWARD_EN compiles in write-to-read forwarding onto rs_o/rt_o.
module rf_write_arbiter #(
    parameter int unsigned R       = 4,
    parameter int unsigned D       = 16,
    parameter int unsigned MAXWAIT = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         wb_valid_i,
    input  logic [R-1:0] wb_addr_i,
    input  logic [D-1:0] wb_data_i,
    output logic         wb_ready_o,
    input  logic         ext_valid_i,
    input  logic [R-1:0] ext_addr_i,
    input  logic [D-1:0] ext_data_i,
    output logic         ext_ready_o,
    output logic         we3_o,
    output logic [R-1:0] wa3_o,
    output logic [D-1:0] wd3_o,
    input  logic [R-1:0] ra1_i,
    input  logic [R-1:0] ra2_i,
    input  logic [D-1:0] rs_raw_i,
    input  logic [D-1:0] rt_raw_i,
    output logic [D-1:0] rs_o,
    output logic [D-1:0] rt_o,
    output logic         ext_forced_o
);

    typedef enum logic {
        WB_PRI    = 1'b0,
        FORCE_EXT = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] wait_cnt;
    logic [3:0] wait_nxt;
    logic       ext_denied;

    always_comb begin
        wb_ready_o  = 1'b0;
        ext_ready_o = 1'b0;
        if (rst_i) begin
            if (state == FORCE_EXT) begin
                ext_ready_o = ext_valid_i;
            end else begin
                wb_ready_o  = wb_valid_i;
                ext_ready_o = ext_valid_i && !wb_valid_i;
            end
        end
    end

    assign ext_denied = ext_valid_i && !ext_ready_o;
    assign wait_nxt   = wait_cnt + 4'd1;

    // FORCE_EXT never denies ext, so it always falls back to WB_PRI after one cycle
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= WB_PRI;
            wait_cnt     <= '0;
            ext_forced_o <= 1'b0;
            we3_o        <= 1'b0;
            wa3_o        <= '0;
            wd3_o        <= '0;
        end else begin
            we3_o <= wb_ready_o || ext_ready_o;
            if (ext_ready_o) begin
                wa3_o <= ext_addr_i;
                wd3_o <= ext_data_i;
            end else if (wb_ready_o) begin
                wa3_o <= wb_addr_i;
                wd3_o <= wb_data_i;
            end

            if (ext_denied) begin
                wait_cnt <= wait_nxt;
                if (wait_nxt == 4'(MAXWAIT)) begin
                    state        <= FORCE_EXT;
                    ext_forced_o <= 1'b1;
                end
            end else begin
                wait_cnt     <= '0;
                state        <= WB_PRI;
                ext_forced_o <= 1'b0;
            end
        end
    end

`ifdef RF_WR_ARB_FORWARD_EN
    assign rs_o = (we3_o && (wa3_o == ra1_i)) ? wd3_o : rs_raw_i;
    assign rt_o = (we3_o && (wa3_o == ra2_i)) ? wd3_o : rt_raw_i;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^{ra1_i, ra2_i};
    assign rs_o = rs_raw_i;
    assign rt_o = rt_raw_i;
`endif

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 The block SHALL expose parameter R, default 4, meaning register address width.
REQ-002 The block SHALL expose parameter D, default 16, meaning register data width.
REQ-003 The block SHALL expose parameter MAXWAIT, default 4, meaning consecutive denied cycles before ext is forced; legal range 1..15.
REQ-004 clk_i  input  1  sole clock; all state on rising edge.
REQ-005 rst_i  input  1  asynchronous, active-low reset.
REQ-006 wb_valid_i  input  1  pipeline writeback request.
REQ-007 wb_addr_i  input  R  writeback destination register.
REQ-008 wb_data_i  input  D  writeback data.
REQ-009 wb_ready_o  output  1  writeback request accepted this cycle.
REQ-010 ext_valid_i  input  1  external (key/DMA loader) write request.
REQ-011 ext_addr_i  input  R  external destination register.
REQ-012 ext_data_i  input  D  external write data.
REQ-013 ext_ready_o  output  1  external request accepted this cycle.
REQ-014 we3_o  output  1  registered write enable to register file port 3.
REQ-015 wa3_o  output  R  registered write address to port 3.
REQ-016 wd3_o  output  D  registered write data to port 3.
REQ-017 ra1_i, ra2_i  input  R each  decode read addresses.
REQ-018 rs_raw_i, rt_raw_i  input  D each  register file read data.
REQ-019 rs_o, rt_o  output  D each  read data delivered to decode.
REQ-020 ext_forced_o  output  1  high while FSM is in FORCE_EXT.

Function
REQ-021 A request SHALL be accepted when its valid and ready are both high at a rising edge; ready SHALL be combinational from valid inputs and FSM state.
REQ-022 At most one of wb_ready_o, ext_ready_o SHALL be high in any cycle; ready SHALL never be high with its valid low.
REQ-023 FSM states SHALL be WB_PRI and FORCE_EXT.
REQ-024 In WB_PRI: wb valid -> wb granted; else ext valid -> ext granted.
REQ-025 Counter wait_cnt (4 bits) SHALL increment each cycle ext_valid_i is high and ext is denied, and clear when ext is granted or ext_valid_i is low.
REQ-026 When wait_cnt reaches MAXWAIT with ext_valid_i high, FSM SHALL move to FORCE_EXT at the next edge.
REQ-027 In FORCE_EXT, ext SHALL be granted (wb denied) for exactly one accepted ext transfer, then FSM returns to WB_PRI and wait_cnt clears.
REQ-028 If ext_valid_i drops while in FORCE_EXT, FSM SHALL return to WB_PRI next edge with no grant.
REQ-029 An accepted request at edge N SHALL appear on we3_o/wa3_o/wd3_o during cycle N+1 (latency 1); we3_o SHALL be low in any cycle following an edge with no acceptance.
REQ-030 Throughput SHALL be one write per cycle; the output register never back-pressures.
REQ-031 Same address requested by both sources SHALL be treated as ordinary contention; only the granted write reaches the port.

Reset
REQ-032 rst_i low SHALL asynchronously force FSM=WB_PRI, wait_cnt=0, we3_o=0, wa3_o=0, wd3_o=0, ext_forced_o=0.
REQ-033 While rst_i is low, wb_ready_o and ext_ready_o SHALL be 0; an in-flight output write SHALL be discarded.
REQ-034 Reset deassertion SHALL take effect synchronously on the first rising edge after release.

Configuration
REQ-035 Macro RF_WR_ARB_FORWARD_EN SHALL compile in write-to-read forwarding.
REQ-036 With RF_WR_ARB_FORWARD_EN defined: rs_o = wd3_o when we3_o and wa3_o==ra1_i, else rs_raw_i; rt_o likewise with ra2_i/rt_raw_i; combinational.
REQ-037 Without it: rs_o = rs_raw_i and rt_o = rt_raw_i unconditionally.

Verification
REQ-038 wb only: wb_valid_i=1, addr=3, data=0x00A5 at edge N -> wb_ready_o=1, cycle N+1 we3_o=1, wa3_o=3, wd3_o=0x00A5.
REQ-039 Contention: both valid continuously, MAXWAIT=4 -> wb granted 4 cycles, ext_forced_o=1 on 5th, ext granted once, then wb resumes; pattern repeats every 5 cycles.
REQ-040 Ext alone: ext_valid_i=1, addr=7, data=0xBEEF -> ext_ready_o=1 same cycle, we3_o=1, wa3_o=7 next cycle, FSM stays WB_PRI.
REQ-041 Forced then withdrawn: reach FORCE_EXT, drop ext_valid_i -> no grant that cycle, FSM back to WB_PRI, wait_cnt=0.
REQ-042 Reset mid-write: accept wb write, assert rst_i=0 before next edge -> we3_o=0 immediately, readies 0; after release, first request accepted normally.
REQ-043 Forwarding (macro on): we3_o=1, wa3_o=5, wd3_o=0x1234, ra1_i=5, rs_raw_i=0x0000 -> rs_o=0x1234; macro off -> rs_o=0x0000.
